fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Parametrised instruction queue between IF1 and decode; successor to the fixed 4-entry, 2-instruction-pop fetch buffer.
- Each entry holds up to two instructions plus their PC and an opaque metadata word (exception, cookie, branch/priv flags, predicted next PC).
- Decode may consume 0, 1 or 2 instructions per cycle. The two-slot output window always presents the oldest remaining instructions, even when they straddle an entry boundary.

Parameters:
DEPTH, 8, number of entries (power of two, >=2)
LOG_DEPTH, 3, log2(DEPTH)
META_W, 46, width of per-entry opaque metadata
AFULL_TH, 2, nearly_full asserts when free entries <= AFULL_TH

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of all contents
in_valid  in  1  IF1 offers an entry
in_ready  out  1  entry accepted this cycle if in_valid
in_mask  in  2  slot valid: bit0 inst0, bit1 inst1; legal values 01, 11; 00 writes nothing
in_inst0  in  32  instruction at in_pc
in_inst1  in  32  instruction at in_pc+4
in_pc  in  32  PC of inst0
in_meta  in  META_W  metadata shared by both instructions of the entry
out_valid  out  2  bit0 slot0 valid, bit1 slot1 valid (10 never driven)
out_inst0  out  32  oldest instruction
out_inst1  out  32  second-oldest instruction
out_pc0  out  32  PC of slot0
out_pc1  out  32  PC of slot1
out_meta0  out  META_W  metadata of slot0's entry
out_meta1  out  META_W  metadata of slot1's entry
pop_cnt  in  2  instructions consumed by decode this cycle (0..2)
entry_cnt  out  LOG_DEPTH+1  occupied entries
nearly_full  out  1  free entries <= AFULL_TH
empty  out  1  no valid instruction present

Behaviour:
- State registers:
  - storage array of DEPTH x {inst0, inst1, pc, mask, meta}
  - rd_ptr and wr_ptr, LOG_DEPTH+1 bits each; MSB distinguishes full from empty
  - head_off (1 bit): 1 when slot inst0 of the head entry is already consumed
- Reset (rstn low, async):
  - ptrs=0, head_off=0, storage unchanged.
  - Outputs: out_valid=00, empty=1, entry_cnt=0, nearly_full=0 (AFULL_TH<DEPTH), in_ready=1.
- Push:
  - Accept when in_valid && in_ready && in_mask!=00 && !flush.
  - Write at wr_ptr; wr_ptr+1 modulo 2*DEPTH.
  - in_ready = entry_cnt<DEPTH, from registered state only; no same-cycle bypass of a full queue by a pop.
  - Write data is visible on the outputs the cycle after acceptance (no write-to-read bypass).
- Output window (combinational from registered state):
  - Head instruction h = head entry slot (head_off).
  - Slot1 comes from the same entry if h is inst0 and mask=11; otherwise it is inst0 of the next entry, if present.
  - out_pc0 = head pc + 4*head_off; out_pc1 is the matching PC.
  - Invalid slots drive inst 0x03400000 (nop), pc `PC_RESET, meta 0.
- Pop:
  - Effective pop = min(pop_cnt, number of valid out slots); excess is ignored, with no underflow.
  - Advance across instructions: each entry consumed completely increments rd_ptr.
  - head_off = 1 iff the new head entry's inst0 is consumed and its inst1 is not.
  - Consuming 2 may retire 0, 1 or 2 entries. Example: head_off=1 with the next entry mask=01 retires 2.
- Simultaneous push and pop: both take effect; entry_cnt = cnt + pushed - retired.
- Flush (sync, highest priority over push and pop): rd_ptr=wr_ptr=0, head_off=0. Same-cycle push is discarded, and outputs show empty next cycle.
- Wrap-around: pointers wrap modulo 2*DEPTH; index = ptr[LOG_DEPTH-1:0].
- Derived outputs: full when ptr MSBs differ and low bits are equal. empty = (rd_ptr==wr_ptr). nearly_full = (DEPTH-entry_cnt) <= AFULL_TH.

Test Plan:
- Reset then push 3 entries (pc 0x1c000000 mask 11, 0x1c000008 mask 01, 0x1c000010 mask 11), pop_cnt=0 -> entry_cnt=3, out_pc0=0x1c000000, out_pc1=0x1c000004, out_valid=11.
- Same fill, pop_cnt=1 each cycle -> out_pc0 sequence 0x1c000000, 0x1c000004, 0x1c000008, 0x1c000010, 0x1c000014. The cycle with head 0x1c000004 shows out_pc1=0x1c000008 with out_meta1 from entry 2. After 5 pops: empty=1, out_valid=00.
- head_off=1 on an 11 entry, next entry mask 01, pop_cnt=2 -> 2 entries retired in one cycle, head_off=0, entry_cnt drops by 2.
- Fill DEPTH=8 entries -> in_ready=0, nearly_full asserted from entry_cnt=6. Push+pop(2 from 11 head) while full -> push refused, entry_cnt=7, in_ready=1 next cycle.
- Flush with in_valid=1 and 5 entries held -> next cycle entry_cnt=0, empty=1, pushed entry absent.
- 20 entries pushed/popped continuously (2/cycle) with 5-entry lag -> PCs and metadata in order across pointer wrap; no loss or duplication. Assert rstn mid-stream -> outputs empty immediately (async).

Source files
------------

// File: rtl/fetch_queue_if.sv
// Handshake and data bundle between IF1, the fetch queue and decode.
// The slave modport is the queue side; the master modport is the
// IF1/decode side that drives entries in and consumes the output window.
interface fetch_queue_if #(
  parameter int META_W    = 46,
  parameter int LOG_DEPTH = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_mask;
  logic [31:0]       in_inst0;
  logic [31:0]       in_inst1;
  logic [31:0]       in_pc;
  logic [META_W-1:0] in_meta;

  logic [1:0]        out_valid;
  logic [31:0]       out_inst0;
  logic [31:0]       out_inst1;
  logic [31:0]       out_pc0;
  logic [31:0]       out_pc1;
  logic [META_W-1:0] out_meta0;
  logic [META_W-1:0] out_meta1;
  logic [1:0]        pop_cnt;

  logic [LOG_DEPTH:0] entry_cnt;
  logic              nearly_full;
  logic              empty;
  logic              flush;

  modport slave (
    input  in_valid, in_mask, in_inst0, in_inst1, in_pc, in_meta, pop_cnt, flush,
    output in_ready, out_valid, out_inst0, out_inst1, out_pc0, out_pc1,
           out_meta0, out_meta1, entry_cnt, nearly_full, empty
  );

  modport master (
    output in_valid, in_mask, in_inst0, in_inst1, in_pc, in_meta, pop_cnt, flush,
    input  in_ready, out_valid, out_inst0, out_inst1, out_pc0, out_pc1,
           out_meta0, out_meta1, entry_cnt, nearly_full, empty
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction queue between IF1 and decode. Each entry carries one or two
// instructions; decode pops 0..2 instructions per cycle from a two-slot
// window that always shows the oldest remaining instructions, even when
// they straddle an entry boundary. head_off marks a half-consumed head.
`ifndef PC_RESET
`define PC_RESET 32'h0000_0000
`endif

module fetch_queue #(
  parameter int DEPTH     = 8,
  parameter int LOG_DEPTH = 3,
  parameter int META_W    = 46,
  parameter int AFULL_TH  = 2
) (
  input logic             clk,
  input logic             rstn,
  fetch_queue_if.slave    bus
);

  localparam logic [31:0] NOP = 32'h0340_0000;

  typedef logic [LOG_DEPTH:0]   ptr_t;
  typedef logic [LOG_DEPTH-1:0] idx_t;

  logic [31:0]       mem_inst0 [DEPTH];
  logic [31:0]       mem_inst1 [DEPTH];
  logic [31:0]       mem_pc    [DEPTH];
  logic [1:0]        mem_mask  [DEPTH];
  logic [META_W-1:0] mem_meta  [DEPTH];

  ptr_t rd_ptr, wr_ptr, cnt, rd_ptr_p1;
  logic head_off, head_off_nxt;
  idx_t head_idx, next_idx;
  logic full, push;
  logic head_present, next_present, head_pair, next_pair;
  logic slot0_v, slot1_v, slot1_same;
  logic [1:0] avail, eff, h_rem, retire;

  assign cnt          = wr_ptr - rd_ptr;
  assign rd_ptr_p1    = rd_ptr + ptr_t'(1);
  assign head_idx     = rd_ptr[LOG_DEPTH-1:0];
  assign next_idx     = rd_ptr_p1[LOG_DEPTH-1:0];
  assign full         = (rd_ptr[LOG_DEPTH] != wr_ptr[LOG_DEPTH]) &&
                        (rd_ptr[LOG_DEPTH-1:0] == wr_ptr[LOG_DEPTH-1:0]);
  assign head_present = (cnt != '0);
  assign next_present = (cnt > ptr_t'(1));
  assign head_pair    = (mem_mask[head_idx] == 2'b11);
  assign next_pair    = (mem_mask[next_idx] == 2'b11);

  // A half-consumed head is always a pair entry, so its second slot comes
  // from the next entry; otherwise a pair head fills both slots itself.
  assign slot1_same = head_present && !head_off && head_pair;
  assign slot0_v    = head_present;
  assign slot1_v    = slot1_same || next_present;

  // Acceptance looks at registered occupancy only; a pop in the same cycle
  // never makes room for a push into a full queue.
  assign bus.in_ready    = !full;
  assign push            = bus.in_valid && !full && (bus.in_mask != 2'b00) && !bus.flush;
  assign bus.entry_cnt   = cnt;
  assign bus.empty       = (rd_ptr == wr_ptr);
  assign bus.nearly_full = ((DEPTH - int'(cnt)) <= AFULL_TH);

  // Output window built from the head entry and, when needed, the next one.
  always_comb begin
    bus.out_valid = {slot1_v, slot0_v};
    bus.out_inst0 = NOP;
    bus.out_pc0   = `PC_RESET;
    bus.out_meta0 = '0;
    bus.out_inst1 = NOP;
    bus.out_pc1   = `PC_RESET;
    bus.out_meta1 = '0;
    if (slot0_v) begin
      bus.out_inst0 = head_off ? mem_inst1[head_idx] : mem_inst0[head_idx];
      bus.out_pc0   = mem_pc[head_idx] + {29'd0, head_off, 2'b00};
      bus.out_meta0 = mem_meta[head_idx];
    end
    if (slot1_same) begin
      bus.out_inst1 = mem_inst1[head_idx];
      bus.out_pc1   = mem_pc[head_idx] + 32'd4;
      bus.out_meta1 = mem_meta[head_idx];
    end else if (next_present) begin
      bus.out_inst1 = mem_inst0[next_idx];
      bus.out_pc1   = mem_pc[next_idx];
      bus.out_meta1 = mem_meta[next_idx];
    end
  end

  // Work out how many entries the effective pop retires and where the new
  // head starts; excess pop requests beyond the visible slots are dropped.
  always_comb begin
    avail        = {1'b0, slot0_v} + {1'b0, slot1_v};
    eff          = (bus.pop_cnt < avail) ? bus.pop_cnt : avail;
    h_rem        = (head_off || !head_pair) ? 2'd1 : 2'd2;
    retire       = 2'd0;
    head_off_nxt = head_off;
    if (eff != 2'd0) begin
      if (eff >= h_rem) begin
        if ((eff - h_rem) == 2'd1) begin
          if (next_pair) begin
            retire       = 2'd1;
            head_off_nxt = 1'b1;
          end else begin
            retire       = 2'd2;
            head_off_nxt = 1'b0;
          end
        end else begin
          retire       = 2'd1;
          head_off_nxt = 1'b0;
        end
      end else begin
        head_off_nxt = 1'b1;
      end
    end
  end

  // Pointer and head-offset state; flush overrides push and pop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      head_off <= 1'b0;
    end else if (bus.flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      head_off <= 1'b0;
    end else begin
      rd_ptr   <= rd_ptr + ptr_t'(retire);
      head_off <= head_off_nxt;
      if (push) wr_ptr <= wr_ptr + ptr_t'(1);
    end
  end

  // Entry storage is not reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst0[wr_ptr[LOG_DEPTH-1:0]] <= bus.in_inst0;
      mem_inst1[wr_ptr[LOG_DEPTH-1:0]] <= bus.in_inst1;
      mem_pc   [wr_ptr[LOG_DEPTH-1:0]] <= bus.in_pc;
      mem_mask [wr_ptr[LOG_DEPTH-1:0]] <= bus.in_mask;
      mem_meta [wr_ptr[LOG_DEPTH-1:0]] <= bus.in_meta;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a vector table for the main sequences,
// then a streaming run across pointer wrap and an async reset check.
module tb_fetch_queue;

  localparam logic [31:0] NOP  = 32'h0340_0000;
  localparam logic [31:0] IOFS = 32'h5000_0000;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  fetch_queue_if #(.META_W(46), .LOG_DEPTH(3)) bus ();

  fetch_queue #(.DEPTH(8), .LOG_DEPTH(3), .META_W(46), .AFULL_TH(2)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  typedef struct packed {
    logic        flush;
    logic        in_v;
    logic [1:0]  mask;
    logic [31:0] pc;
    logic [1:0]  pop;
    logic [1:0]  e_v;
    logic [31:0] e_pc0;
    logic [31:0] e_pc1;
    logic [3:0]  e_cnt;
    logic        e_rdy;
    logic        e_empty;
    logic        e_nf;
  } vec_t;

  function automatic logic [45:0] meta_of(logic [31:0] p);
    return {14'h2a5, p[31:3], 3'b000};
  endfunction

  task automatic drive(logic fl, logic iv, logic [1:0] m, logic [31:0] p, logic [1:0] pc);
    bus.flush    = fl;
    bus.in_valid = iv;
    bus.in_mask  = m;
    bus.in_pc    = p;
    bus.in_inst0 = p + IOFS;
    bus.in_inst1 = p + 32'd4 + IOFS;
    bus.in_meta  = meta_of(p);
    bus.pop_cnt  = pc;
  endtask

  task automatic check(string name, logic [1:0] ev, logic [31:0] epc0, logic [31:0] epc1,
                       logic [3:0] ecnt, logic erdy, logic eempty, logic enf);
    logic [31:0] ei0, ei1, p0, p1;
    logic [45:0] em0, em1;
    p0  = ev[0] ? epc0 : 32'h0;
    p1  = ev[1] ? epc1 : 32'h0;
    ei0 = ev[0] ? epc0 + IOFS : NOP;
    ei1 = ev[1] ? epc1 + IOFS : NOP;
    em0 = ev[0] ? meta_of(epc0) : '0;
    em1 = ev[1] ? meta_of(epc1) : '0;
    n_vec++;
    if (bus.out_valid !== ev || bus.out_pc0 !== p0 || bus.out_pc1 !== p1 ||
        bus.out_inst0 !== ei0 || bus.out_inst1 !== ei1 ||
        bus.out_meta0 !== em0 || bus.out_meta1 !== em1 ||
        bus.entry_cnt !== ecnt || bus.in_ready !== erdy ||
        bus.empty !== eempty || bus.nearly_full !== enf) begin
      n_bad++;
      $display("FAIL %s: got v=%b pc0=%h pc1=%h i0=%h i1=%h m0=%h m1=%h cnt=%0d rdy=%b e=%b nf=%b; want v=%b pc0=%h pc1=%h i0=%h i1=%h m0=%h m1=%h cnt=%0d rdy=%b e=%b nf=%b",
               name, bus.out_valid, bus.out_pc0, bus.out_pc1, bus.out_inst0, bus.out_inst1,
               bus.out_meta0, bus.out_meta1, bus.entry_cnt, bus.in_ready, bus.empty,
               bus.nearly_full, ev, p0, p1, ei0, ei1, em0, em1, ecnt, erdy, eempty, enf);
    end
  endtask

  vec_t tbl [37];

  initial begin
    // flush in_v mask pc pop | valid pc0 pc1 cnt rdy empty nf  (seen while presented)
    tbl[0]  = '{1'b0,1'b1,2'b11,32'h1c000000,2'd0, 2'b00,32'h0,32'h0,4'd0,1'b1,1'b1,1'b0};
    tbl[1]  = '{1'b0,1'b1,2'b01,32'h1c000008,2'd0, 2'b11,32'h1c000000,32'h1c000004,4'd1,1'b1,1'b0,1'b0};
    tbl[2]  = '{1'b0,1'b1,2'b11,32'h1c000010,2'd0, 2'b11,32'h1c000000,32'h1c000004,4'd2,1'b1,1'b0,1'b0};
    tbl[3]  = '{1'b0,1'b0,2'b00,32'h0,2'd0,        2'b11,32'h1c000000,32'h1c000004,4'd3,1'b1,1'b0,1'b0};
    tbl[4]  = '{1'b0,1'b0,2'b00,32'h0,2'd1,        2'b11,32'h1c000000,32'h1c000004,4'd3,1'b1,1'b0,1'b0};
    tbl[5]  = '{1'b0,1'b0,2'b00,32'h0,2'd1,        2'b11,32'h1c000004,32'h1c000008,4'd3,1'b1,1'b0,1'b0};
    tbl[6]  = '{1'b0,1'b0,2'b00,32'h0,2'd1,        2'b11,32'h1c000008,32'h1c000010,4'd2,1'b1,1'b0,1'b0};
    tbl[7]  = '{1'b0,1'b0,2'b00,32'h0,2'd1,        2'b11,32'h1c000010,32'h1c000014,4'd1,1'b1,1'b0,1'b0};
    tbl[8]  = '{1'b0,1'b0,2'b00,32'h0,2'd1,        2'b01,32'h1c000014,32'h0,4'd1,1'b1,1'b0,1'b0};
    tbl[9]  = '{1'b0,1'b0,2'b00,32'h0,2'd1,        2'b00,32'h0,32'h0,4'd0,1'b1,1'b1,1'b0};
    tbl[10] = '{1'b0,1'b0,2'b00,32'h0,2'd0,        2'b00,32'h0,32'h0,4'd0,1'b1,1'b1,1'b0};
    tbl[11] = '{1'b0,1'b1,2'b11,32'h1c000020,2'd0, 2'b00,32'h0,32'h0,4'd0,1'b1,1'b1,1'b0};
    tbl[12] = '{1'b0,1'b1,2'b01,32'h1c000028,2'd1, 2'b11,32'h1c000020,32'h1c000024,4'd1,1'b1,1'b0,1'b0};
    tbl[13] = '{1'b0,1'b1,2'b11,32'h1c000030,2'd2, 2'b11,32'h1c000024,32'h1c000028,4'd2,1'b1,1'b0,1'b0};
    tbl[14] = '{1'b0,1'b0,2'b00,32'h0,2'd0,        2'b11,32'h1c000030,32'h1c000034,4'd1,1'b1,1'b0,1'b0};
    tbl[15] = '{1'b0,1'b0,2'b00,32'h0,2'd2,        2'b11,32'h1c000030,32'h1c000034,4'd1,1'b1,1'b0,1'b0};
    tbl[16] = '{1'b0,1'b0,2'b00,32'h0,2'd0,        2'b00,32'h0,32'h0,4'd0,1'b1,1'b1,1'b0};
    for (int k = 0; k < 8; k++) begin
      tbl[17+k] = '{1'b0,1'b1,2'b11,32'h1c000100 + 32'(8*k),2'd0,
                    (k == 0) ? 2'b00 : 2'b11,
                    (k == 0) ? 32'h0 : 32'h1c000100,
                    (k == 0) ? 32'h0 : 32'h1c000104,
                    4'(k), 1'b1, (k == 0), (k >= 6)};
    end
    tbl[25] = '{1'b0,1'b1,2'b11,32'h1c000200,2'd2, 2'b11,32'h1c000100,32'h1c000104,4'd8,1'b0,1'b0,1'b1};
    tbl[26] = '{1'b0,1'b0,2'b00,32'h0,2'd0,        2'b11,32'h1c000108,32'h1c00010c,4'd7,1'b1,1'b0,1'b1};
    tbl[27] = '{1'b0,1'b0,2'b00,32'h0,2'd2,        2'b11,32'h1c000108,32'h1c00010c,4'd7,1'b1,1'b0,1'b1};
    tbl[28] = '{1'b0,1'b0,2'b00,32'h0,2'd2,        2'b11,32'h1c000110,32'h1c000114,4'd6,1'b1,1'b0,1'b1};
    tbl[29] = '{1'b1,1'b1,2'b11,32'h1c000300,2'd0, 2'b11,32'h1c000118,32'h1c00011c,4'd5,1'b1,1'b0,1'b0};
    tbl[30] = '{1'b0,1'b0,2'b00,32'h0,2'd0,        2'b00,32'h0,32'h0,4'd0,1'b1,1'b1,1'b0};
    tbl[31] = '{1'b0,1'b1,2'b01,32'h1c000400,2'd0, 2'b00,32'h0,32'h0,4'd0,1'b1,1'b1,1'b0};
    tbl[32] = '{1'b0,1'b0,2'b00,32'h0,2'd0,        2'b01,32'h1c000400,32'h0,4'd1,1'b1,1'b0,1'b0};
    tbl[33] = '{1'b0,1'b0,2'b00,32'h0,2'd2,        2'b01,32'h1c000400,32'h0,4'd1,1'b1,1'b0,1'b0};
    tbl[34] = '{1'b0,1'b0,2'b00,32'h0,2'd0,        2'b00,32'h0,32'h0,4'd0,1'b1,1'b1,1'b0};
    tbl[35] = '{1'b0,1'b1,2'b00,32'h1c000500,2'd0, 2'b00,32'h0,32'h0,4'd0,1'b1,1'b1,1'b0};
    tbl[36] = '{1'b0,1'b0,2'b00,32'h0,2'd0,        2'b00,32'h0,32'h0,4'd0,1'b1,1'b1,1'b0};

    drive(1'b0, 1'b0, 2'b00, 32'h0, 2'd0);
    #2;
    check("reset", 2'b00, 32'h0, 32'h0, 4'd0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 37; i++) begin
      @(negedge clk);
      drive(tbl[i].flush, tbl[i].in_v, tbl[i].mask, tbl[i].pc, tbl[i].pop);
      #1;
      check($sformatf("vec%0d", i), tbl[i].e_v, tbl[i].e_pc0, tbl[i].e_pc1,
            tbl[i].e_cnt, tbl[i].e_rdy, tbl[i].e_empty, tbl[i].e_nf);
    end

    // Continuous stream of 20 pair entries, popping 2/cycle after a 5-entry lag.
    for (int c = 0; c < 26; c++) begin
      int pushed, popped, cnt;
      pushed = (c < 20) ? c : 20;
      popped = (c > 5) ? c - 5 : 0;
      cnt    = pushed - popped;
      @(negedge clk);
      drive(1'b0, c < 20, 2'b11, 32'h1c008000 + 32'(8*c), (c >= 5) ? 2'd2 : 2'd0);
      #1;
      if (cnt == 0)
        check($sformatf("stream%0d", c), 2'b00, 32'h0, 32'h0, 4'd0, 1'b1, 1'b1, 1'b0);
      else
        check($sformatf("stream%0d", c), 2'b11, 32'h1c008000 + 32'(8*popped),
              32'h1c008004 + 32'(8*popped), 4'(cnt), 1'b1, 1'b0, 1'b0);
    end

    // Asynchronous reset mid-stream clears the queue without a clock edge.
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b11, 32'h1c00a000, 2'd0);
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b01, 32'h1c00a008, 2'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 32'h0, 2'd0);
    #1;
    check("pre_rst", 2'b11, 32'h1c00a000, 32'h1c00a004, 4'd2, 1'b1, 1'b0, 1'b0);
    #1;
    rstn = 1'b0;
    #1;
    check("async_rst", 2'b00, 32'h0, 32'h0, 4'd0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst", 2'b00, 32'h0, 32'h0, 4'd0, 1'b1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
